// File: rtl/nco_lut_scheduler.sv
// nco_lut_scheduler: round-robin sharing of one quarter-wave sine LUT among NCO requesters (optional cos select via NCO_LUT_SCHED_COS_EN)
module nco_lut_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int PHASE_W = 8,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 14,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*PHASE_W-1:0] req_phase,
`ifdef NCO_LUT_SCHED_COS_EN
  input  logic [NUM_REQ-1:0]         req_cos,
`endif
  output logic [ADDR_W-1:0]          lut_addr,
  input  logic [DATA_W-1:0]          lut_data,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [DATA_W:0]            rsp_sample
);
  logic [ID_W-1:0]      rr, gnt_id, idx, id_q;
  logic                 gnt_any, inflight, neg_q, credit, pop, rd, wr;
  logic [1:0]           occ, quad;
  logic [2:0]           load;
  logic [PHASE_W-1:0]   ph [NUM_REQ];
  logic [ADDR_W-1:0]    a;
  logic [DATA_W:0]      sample;
  logic [ID_W+DATA_W:0] mem [2];

  assign pop       = rsp_valid & rsp_ready;
  assign load      = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
  assign credit    = load < 3'd2;
  assign rsp_valid = occ != 2'd0;
  assign {rsp_id, rsp_sample} = mem[rd];
  assign req_ready = gnt_any ? NUM_REQ'(1) << gnt_id : '0;
  assign sample    = neg_q ? -{1'b0, lut_data} : {1'b0, lut_data};

  // unpack phases, pick first valid requester at or after rr, fold quadrant into address and sign
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) ph[i] = req_phase[i*PHASE_W +: PHASE_W];
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr) + k) % NUM_REQ);
      if (credit && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
`ifdef NCO_LUT_SCHED_COS_EN
    quad = ph[gnt_id][PHASE_W-1 -: 2] + {1'b0, req_cos[gnt_id]};
`else
    quad = ph[gnt_id][PHASE_W-1 -: 2];
`endif
    a        = ph[gnt_id][ADDR_W-1:0];
    lut_addr = gnt_any ? (quad[0] ? ~a : a) : '0;
  end

  // issue tracking, rr pointer update and the 2-entry output FIFO
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr       <= '0;
      inflight <= 1'b0;
      neg_q    <= 1'b0;
      id_q     <= '0;
      occ      <= '0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      inflight <= gnt_any;
      if (gnt_any) begin
        rr    <= gnt_id == ID_W'(NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
        neg_q <= quad[1];
        id_q  <= gnt_id;
      end
      if (inflight) begin
        mem[wr] <= {id_q, sample};
        wr      <= ~wr;
      end
      if (pop) rd <= ~rd;
      occ <= occ + {1'b0, inflight} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_nco_lut_scheduler.sv
// tb_nco_lut_scheduler: directed vector bench for nco_lut_scheduler with a behavioural LUT
module tb_nco_lut_scheduler;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  ph0 = '0, ph1 = '0;
  logic [1:0]  req_cos = '0;
  logic [5:0]  lut_addr;
  logic [13:0] lut_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [0:0]  rsp_id;
  logic [14:0] rsp_sample;
  int          nvec = 0, nerr = 0;

  nco_lut_scheduler dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_phase({ph1, ph0}),
`ifdef NCO_LUT_SCHED_COS_EN
    .req_cos(req_cos),
`endif
    .lut_addr(lut_addr), .lut_data(lut_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sample(rsp_sample)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] lut_f(input logic [5:0] a);
    case (a)
      6'd0:    return 14'h0000;
      6'd32:   return 14'h2D41;
      6'd62:   return 14'h3FEC;
      6'd63:   return 14'h3FFB;
      default: return 14'(int'(a) * 200 + 1);
    endcase
  endfunction

  always @(posedge clock) lut_data <= lut_f(lut_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    req_valid = '0;
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic [0:0]  r;
    logic [7:0]  ph;
    logic        cos;
    logic [14:0] smp;
  } vec_t;

  vec_t vt [10];
  int   nv;

  initial begin
    vt[0] = '{1'b0, 8'h00, 1'b0, 15'h0000};
    vt[1] = '{1'b1, 8'h40, 1'b0, 15'h3FFB};
    vt[2] = '{1'b1, 8'hA0, 1'b0, 15'h52BF};
    vt[3] = '{1'b1, 8'hC1, 1'b0, 15'h4014};
    vt[4] = '{1'b0, 8'h20, 1'b0, 15'h2D41};
    vt[5] = '{1'b0, 8'h7F, 1'b0, 15'h0000};
    vt[6] = '{1'b0, 8'h85, 1'b0, 15'h7C17};
    vt[7] = '{1'b1, 8'hFF, 1'b0, 15'h0000};
    vt[8] = '{1'b0, 8'h00, 1'b1, 15'h3FFB};
    vt[9] = '{1'b1, 8'h40, 1'b1, 15'h0000};
`ifdef NCO_LUT_SCHED_COS_EN
    nv = 10;
`else
    nv = 8;
`endif
    cyc();
    do_reset();
    chk("reset rsp_valid", 32'(rsp_valid), 0);
    chk("reset rsp_id", 32'(rsp_id), 0);
    chk("reset rsp_sample", 32'(rsp_sample), 0);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("idle lut_addr", 32'(lut_addr), 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < nv; i++) begin
      req_valid = 2'(1) << vt[i].r;
      ph0 = vt[i].ph;
      ph1 = vt[i].ph;
      req_cos = {2{vt[i].cos}};
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(2'(1) << vt[i].r));
      cyc();
      req_valid = '0;
      chk($sformatf("v%0d early valid", i), 32'(rsp_valid), 0);
      cyc();
      chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 1);
      chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vt[i].r));
      chk($sformatf("v%0d rsp_sample", i), 32'(rsp_sample), 32'(vt[i].smp));
      cyc();
      chk($sformatf("v%0d drained", i), 32'(rsp_valid), 0);
    end
    req_cos = '0;
    // full-throughput alternation
    do_reset();
    ph0 = 8'h20;
    ph1 = 8'hA0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr%0d req_ready", k), 32'(req_ready), (k % 2 == 0) ? 1 : 2);
      if (k >= 2) begin
        chk($sformatf("rr%0d rsp_valid", k), 32'(rsp_valid), 1);
        chk($sformatf("rr%0d rsp_id", k), 32'(rsp_id), 32'(k % 2));
        chk($sformatf("rr%0d rsp_sample", k), 32'(rsp_sample), (k % 2 == 0) ? 32'h2D41 : 32'h52BF);
      end
      cyc();
    end
    // backpressure: two accepts then stall, release drains in order
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    #1;
    chk("bp c0 ready", 32'(req_ready), 1);
    cyc();
    chk("bp c1 ready", 32'(req_ready), 2);
    cyc();
    chk("bp c2 ready", 32'(req_ready), 0);
    cyc();
    chk("bp c3 ready", 32'(req_ready), 0);
    chk("bp c3 id", 32'(rsp_id), 0);
    cyc();
    chk("bp c4 ready", 32'(req_ready), 0);
    chk("bp c4 valid", 32'(rsp_valid), 1);
    chk("bp c4 hold id", 32'(rsp_id), 0);
    chk("bp c4 hold sample", 32'(rsp_sample), 32'h2D41);
    rsp_ready = 1'b1;
    #1;
    chk("bp c5 ready", 32'(req_ready), 1);
    cyc();
    chk("bp c6 valid", 32'(rsp_valid), 1);
    chk("bp c6 id", 32'(rsp_id), 1);
    chk("bp c6 sample", 32'(rsp_sample), 32'h52BF);
    chk("bp c6 ready", 32'(req_ready), 2);
    cyc();
    chk("bp c7 id", 32'(rsp_id), 0);
    chk("bp c7 valid", 32'(rsp_valid), 1);
    // reset with buffered and in-flight work
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    cyc();
    cyc();
    cyc();
    reset_n = 1'b0;
    cyc();
    chk("mrst valid", 32'(rsp_valid), 0);
    chk("mrst sample", 32'(rsp_sample), 0);
    cyc();
    chk("mrst valid2", 32'(rsp_valid), 0);
    reset_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("mrst first grant", 32'(req_ready), 1);
    cyc();
    chk("mrst no stale", 32'(rsp_valid), 0);
    cyc();
    chk("mrst rsp_valid", 32'(rsp_valid), 1);
    chk("mrst rsp_id", 32'(rsp_id), 0);
    req_valid = '0;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
